top_level: RTL and testbench
============================

TOP_LEVEL -- requirements
Module: top_level

Interface
REQ-001 Parameter MSG_BASE, default 64, is the data-memory address of the first encrypted byte.
REQ-002 Parameter MSG_LEN, default 64, is the number of encrypted input bytes and of output bytes.
REQ-003 Parameter PRE_MIN, default 10, is the guaranteed minimum count of leading 0x20 pad bytes.
REQ-004 Clk  input  1  system clock; all state updates on the rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Start  input  1  high = hold idle; a high-to-low transition (Start low while idle) launches one run.
REQ-007 Ack  output  1  run complete flag.
REQ-008 Data memory SHALL be an internal instance named mem with array Core[0:255] of 8-bit words, hierarchically preloadable and readable by the bench.

Function
REQ-009 Input bytes: Core[MSG_BASE+i], i=0..63; bit7 = even-parity bit over bits 6:0; bits 6:0 = plaintext[6:0] XOR lfsr[i].
REQ-010 LFSR step: next = {s[5:0], ^(s & ptrn)}, 7 bits; lfsr[0] = init.
REQ-011 Candidate ptrns, tried in order: 0x60,0x48,0x78,0x72,0x6A,0x69,0x5C,0x7E,0x7B.
REQ-012 init SHALL be Core[MSG_BASE][6:0] XOR 0x20.
REQ-013 Pattern search: first candidate whose lfsr[k] equals Core[MSG_BASE+k][6:0] XOR 0x20 for all k=1..PRE_MIN-1 is selected; if none matches, select 0x60.
REQ-014 Decrypt d[i] = Core[MSG_BASE+i][6:0] XOR lfsr[i], i=0..63.
REQ-015 Error e[i] = XOR of all 8 bits of Core[MSG_BASE+i] (1 = parity violation).
REQ-016 Shift L = count of leading i from 0 with d[i]==0x20 and e[i]==0; scan stops at the first non-space or errored byte; L<=63.
REQ-017 Output Core[n], n=0..63: if n+L<64, write {e[n+L], d[n+L]}; else write 0x20.
REQ-018 Only Core[0..63] SHALL be written; Core[64..255] unchanged by the run.
REQ-019 FSM states: IDLE, FIND_PTRN, SCAN_LEAD, DECRYPT_WRITE, DONE.
REQ-020 IDLE -> FIND_PTRN when Start==0; FIND_PTRN -> SCAN_LEAD on pattern chosen; SCAN_LEAD -> DECRYPT_WRITE when L fixed; DECRYPT_WRITE -> DONE after write n=63.
REQ-021 At most one memory write per cycle; memory reads combinational (asynchronous) from Core.
REQ-022 Total run latency from launch to Ack SHALL be <= 2000 cycles.
REQ-023 Ack SHALL rise in the cycle after the last write and stay high in DONE until Reset; Start high in DONE returns to IDLE with Ack low.
REQ-024 Start held high continuously keeps FSM in IDLE; no memory writes.

Reset
REQ-025 Reset high: FSM to IDLE, Ack=0, LFSR/pattern/L/index registers cleared, on the next rising edge.
REQ-026 Reset SHALL NOT clear Core contents (bench preloads while Reset is high).
REQ-027 Reset mid-run aborts; partial Core[0..63] results may remain; a new run needs Reset low and Start low.
REQ-028 Start low while Reset high SHALL NOT launch; launch occurs only after Reset deasserts.

Verification
REQ-029 "Mr. Watson, come here. I want to see you.", ptrn 0x60, init 0x01, 10 pad bytes, no corruption -> Core[0]=0x4D, Core[40]=0x2E, Core[41..63]=0x20, Ack=1.
REQ-030 Same message, ptrn 0x7B, init 0x55, 15 pad bytes -> identical Core[0..63] to REQ-029.
REQ-031 " Knowledge comes, but wisdom lingers.    ", 12 pad -> L=13, Core[0]=0x4B ('K').
REQ-032 REQ-029 setup with bit 0 of Core[100] flipped -> Core[26][7]=1; all other Core[0..63] as REQ-029.
REQ-033 Random bit flips in Core[88..127] (single bit each, bits 0..7) -> every flipped byte's output has bit7=1, all unflipped outputs bit7=0 and correct; score 64/64.
REQ-034 Reset pulsed mid-DECRYPT_WRITE -> Ack=0 next cycle; relaunch produces REQ-029 results.

Source files
------------

// File: rtl/top_level.sv
// top_level: parity-checked LFSR stream decrypter with tap search and leading-space strip
module data_mem (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] wa,
    input  logic [7:0] wd,
    input  logic [7:0] ra,
    output logic [7:0] rd
);
    logic [7:0] Core [0:255];
    // Single write port; contents are never reset so they can be preloaded
    always_ff @(posedge clk) begin
        if (we) Core[wa] <= wd;
    end
    assign rd = Core[ra];
endmodule

module top_level #(
    parameter int MSG_BASE = 64,
    parameter int MSG_LEN  = 64,
    parameter int PRE_MIN  = 10
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Start,
    output logic Ack
);
    typedef enum logic [2:0] {IDLE, FIND_PTRN, SCAN_LEAD, DECRYPT_WRITE, DONE} state_t;
    state_t     state_q, state_d;
    logic [3:0] pi_q, pi_d;
    logic [6:0] k_q, k_d, n_q, n_d, lfsr_q, lfsr_d, init_q, init_d, ptrn_q, ptrn_d;
    logic       we, err;
    logic [7:0] wa, wd, ra, rd;
    logic [6:0] cand, cur, nxt, dec;

    function automatic logic [6:0] step(input logic [6:0] s, input logic [6:0] p);
        return {s[5:0], ^(s & p)};
    endfunction

    data_mem mem (.clk(Clk), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd));

    // k_q walks the message: pad index while searching, source index afterwards
    assign ra  = 8'(MSG_BASE) + {1'b0, k_q};
    assign cur = (state_q == FIND_PTRN) ? cand : ptrn_q;
    assign nxt = step(lfsr_q, cur);
    assign dec = rd[6:0] ^ lfsr_q;
    assign err = ^rd;
    assign Ack = (state_q == DONE);

    // Candidate feedback taps in search order
    always_comb begin
        case (pi_q)
            4'd1:    cand = 7'h48;
            4'd2:    cand = 7'h78;
            4'd3:    cand = 7'h72;
            4'd4:    cand = 7'h6A;
            4'd5:    cand = 7'h69;
            4'd6:    cand = 7'h5C;
            4'd7:    cand = 7'h7E;
            4'd8:    cand = 7'h7B;
            default: cand = 7'h60;
        endcase
    end

    // Next-state and datapath control; one memory read and at most one write per cycle
    always_comb begin
        state_d = state_q;
        pi_d    = pi_q;
        k_d     = k_q;
        n_d     = n_q;
        lfsr_d  = lfsr_q;
        init_d  = init_q;
        ptrn_d  = ptrn_q;
        we      = 1'b0;
        wa      = {1'b0, n_q};
        wd      = 8'h20;
        case (state_q)
            IDLE: begin
                if (!Start) begin
                    state_d = FIND_PTRN;
                    pi_d    = '0;
                    k_d     = '0;
                end
            end
            FIND_PTRN: begin
                if (k_q == 7'd0) begin
                    init_d = rd[6:0] ^ 7'h20;
                    lfsr_d = init_d;
                    k_d    = 7'd1;
                    if (PRE_MIN < 2) begin
                        ptrn_d  = cur;
                        state_d = SCAN_LEAD;
                        k_d     = '0;
                    end
                end else if (nxt == (rd[6:0] ^ 7'h20)) begin
                    lfsr_d = nxt;
                    k_d    = k_q + 7'd1;
                    if (k_q == 7'(PRE_MIN - 1)) begin
                        ptrn_d  = cur;
                        state_d = SCAN_LEAD;
                        lfsr_d  = init_q;
                        k_d     = '0;
                    end
                end else begin
                    pi_d = pi_q + 4'd1;
                    k_d  = '0;
                    if (pi_q == 4'd8) begin
                        ptrn_d  = 7'h60;
                        state_d = SCAN_LEAD;
                        lfsr_d  = init_q;
                    end
                end
            end
            SCAN_LEAD: begin
                if (dec == 7'h20 && !err && k_q < 7'(MSG_LEN - 1)) begin
                    k_d    = k_q + 7'd1;
                    lfsr_d = nxt;
                end else begin
                    n_d     = '0;
                    state_d = DECRYPT_WRITE;
                end
            end
            DECRYPT_WRITE: begin
                we = 1'b1;
                wd = (k_q < 7'(MSG_LEN)) ? {err, dec} : 8'h20;
                if (k_q < 7'(MSG_LEN)) begin
                    k_d    = k_q + 7'd1;
                    lfsr_d = nxt;
                end
                n_d = n_q + 7'd1;
                if (n_q == 7'(MSG_LEN - 1)) state_d = DONE;
            end
            DONE: begin
                if (Start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pi_q    <= '0;
            k_q     <= '0;
            n_q     <= '0;
            lfsr_q  <= '0;
            init_q  <= '0;
            ptrn_q  <= '0;
        end else begin
            state_q <= state_d;
            pi_q    <= pi_d;
            k_q     <= k_d;
            n_q     <= n_d;
            lfsr_q  <= lfsr_d;
            init_q  <= init_d;
            ptrn_q  <= ptrn_d;
        end
    end
endmodule

// File: tb/tb_top_level.sv
// tb_top_level: randomized and directed checks of top_level against a behavioural decrypt model
module tb_top_level;
    localparam int MB = 64;
    localparam int ML = 64;
    localparam int PM = 10;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic Start = 1'b1;
    logic Ack;

    top_level #(.MSG_BASE(MB), .MSG_LEN(ML), .PRE_MIN(PM)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] img [0:255];
    logic [6:0] pt [0:63];
    logic [7:0] exp_out [0:63];
    logic [7:0] ref29 [0:63];
    bit fl [0:255];
    int exp_L;
    bit armed = 1'b0;

    function automatic logic [6:0] step(input logic [6:0] s, input logic [6:0] p);
        return {s[5:0], ^(s & p)};
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, req);
        end
    endtask

    // Expected Core[0..63] and shift L computed straight from the input image
    function automatic void model();
        logic [6:0] taps [0:8];
        logic [6:0] lf [0:64];
        logic [6:0] d [0:63];
        logic       e [0:63];
        logic [6:0] s, init, p;
        bit ok, found;
        taps = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
        init = img[MB][6:0] ^ 7'h20;
        p = 7'h60;
        found = 1'b0;
        for (int j = 0; j < 9; j++) begin
            if (!found) begin
                ok = 1'b1;
                s = init;
                for (int k = 1; k < PM; k++) begin
                    s = step(s, taps[j]);
                    if (s != (img[MB+k][6:0] ^ 7'h20)) ok = 1'b0;
                end
                if (ok) begin
                    p = taps[j];
                    found = 1'b1;
                end
            end
        end
        lf[0] = init;
        for (int i = 0; i < 64; i++) lf[i+1] = step(lf[i], p);
        for (int i = 0; i < 64; i++) begin
            d[i] = img[MB+i][6:0] ^ lf[i];
            e[i] = ^img[MB+i];
        end
        exp_L = 0;
        while (exp_L < 63 && d[exp_L] == 7'h20 && !e[exp_L]) exp_L++;
        for (int n = 0; n < 64; n++)
            exp_out[n] = (n + exp_L < 64) ? {e[n+exp_L], d[n+exp_L]} : 8'h20;
    endfunction

    task automatic set_msg(input string m, input int pad);
        byte b;
        for (int i = 0; i < 64; i++) begin
            if (i < pad || i - pad >= m.len()) pt[i] = 7'h20;
            else begin
                b = m[i-pad];
                pt[i] = b[6:0];
            end
        end
    endtask

    task automatic encrypt(input logic [6:0] p, input logic [6:0] init);
        logic [6:0] s, c;
        s = init;
        for (int i = 0; i < 256; i++) begin
            img[i] = 8'($urandom);
            fl[i] = 1'b0;
        end
        for (int i = 0; i < 64; i++) img[i] = 8'hAA;
        for (int i = 0; i < 64; i++) begin
            c = pt[i] ^ s;
            img[MB+i] = {^c, c};
            s = step(s, p);
        end
    endtask

    task automatic load_img();
        Reset = 1'b1;
        Start = 1'b1;
        @(posedge Clk); #1;
        for (int i = 0; i < 256; i++) dut.mem.Core[i] = img[i];
        model();
        chk("reset_ack", Ack, 0);
    endtask

    task automatic go(input string nm);
        int cyc, bad;
        Reset = 1'b0;
        Start = 1'b0;
        armed = 1'b1;
        cyc = 0;
        while (!Ack && cyc < 2000) begin
            @(posedge Clk); #1;
            cyc++;
        end
        chk({nm, "_ack_in_time"}, Ack, 1);
        for (int i = 0; i < 64; i++)
            chk($sformatf("%s_core%0d", nm, i), dut.mem.Core[i], exp_out[i]);
        bad = 0;
        for (int i = 64; i < 256; i++) if (dut.mem.Core[i] !== img[i]) bad++;
        chk({nm, "_upper_untouched_diffs"}, bad, 0);
        repeat (2) begin @(posedge Clk); #1; end
        chk({nm, "_ack_hold"}, Ack, 1);
        armed = 1'b0;
        Start = 1'b1;
        @(posedge Clk); #1;
        chk({nm, "_ack_clear"}, Ack, 0);
    endtask

    // Whenever Ack is high the whole memory image must already match the model
    always @(negedge Clk) begin
        int bad;
        if (armed && Ack) begin
            bad = 0;
            for (int i = 0; i < 64; i++) if (dut.mem.Core[i] !== exp_out[i]) bad++;
            for (int i = 64; i < 256; i++) if (dut.mem.Core[i] !== img[i]) bad++;
            n_cmp++;
            if (bad != 0) begin
                n_bad++;
                $display("FAIL ack_image: %0d bytes differ from model, want 0", bad);
            end
        end
    end

    initial begin
        int bad, pad;
        logic [6:0] taps [0:8];
        taps = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
        repeat (2) @(posedge Clk);

        // Watson, tap 0x60, init 0x01, 10 pad; idle and reset-hold guards first
        set_msg("Mr. Watson, come here. I want to see you.", 10);
        encrypt(7'h60, 7'h01);
        load_img();
        chk("model_L_watson", exp_L, 10);
        Reset = 1'b0;
        Start = 1'b1;
        repeat (20) @(posedge Clk); #1;
        chk("start_high_idle_ack", Ack, 0);
        bad = 0;
        for (int i = 0; i < 64; i++) if (dut.mem.Core[i] !== 8'hAA) bad++;
        chk("start_high_no_writes", bad, 0);
        Reset = 1'b1;
        Start = 1'b0;
        repeat (5) @(posedge Clk); #1;
        chk("reset_blocks_launch_ack", Ack, 0);
        bad = 0;
        for (int i = 0; i < 64; i++) if (dut.mem.Core[i] !== 8'hAA) bad++;
        chk("reset_blocks_launch_writes", bad, 0);
        go("watson");
        chk("watson_core0_lit", dut.mem.Core[0], 8'h4D);
        chk("watson_core40_lit", dut.mem.Core[40], 8'h2E);
        chk("watson_core41_lit", dut.mem.Core[41], 8'h20);
        chk("watson_core63_lit", dut.mem.Core[63], 8'h20);
        for (int i = 0; i < 64; i++) ref29[i] = exp_out[i];

        // Same text, last tap, longer pad
        set_msg("Mr. Watson, come here. I want to see you.", 15);
        encrypt(7'h7B, 7'h55);
        load_img();
        go("watson_7b");
        bad = 0;
        for (int i = 0; i < 64; i++) if (dut.mem.Core[i] !== ref29[i]) bad++;
        chk("watson_7b_same_as_60", bad, 0);

        // Extra leading space in the message itself
        set_msg(" Knowledge comes, but wisdom lingers.    ", 12);
        encrypt(7'h72, 7'h2B);
        load_img();
        chk("model_L_knowledge", exp_L, 13);
        go("knowledge");
        chk("knowledge_core0_lit", dut.mem.Core[0], 8'h4B);

        // Single parity error at Core[100]
        set_msg("Mr. Watson, come here. I want to see you.", 10);
        encrypt(7'h60, 7'h01);
        img[100] = img[100] ^ 8'h01;
        load_img();
        go("flip100");
        chk("flip100_bit7", dut.mem.Core[26][7], 1);
        bad = 0;
        for (int i = 0; i < 64; i++) if (i != 26 && dut.mem.Core[i] !== ref29[i]) bad++;
        chk("flip100_others", bad, 0);

        // Random single-bit flips across Core[88..127]
        encrypt(7'h60, 7'h01);
        for (int a = 88; a < 128; a++) begin
            if ($urandom_range(0, 1) == 1) begin
                img[a] = img[a] ^ (8'h01 << $urandom_range(0, 7));
                fl[a] = 1'b1;
            end
        end
        load_img();
        go("flips");
        for (int n = 0; n < 64; n++) begin
            if (n + 10 < 64 && fl[MB+n+10]) chk($sformatf("flips_err%0d", n), dut.mem.Core[n][7], 1);
            else chk($sformatf("flips_ok%0d", n), dut.mem.Core[n], ref29[n]);
        end

        // All spaces: shift saturates at 63
        set_msg("", 64);
        encrypt(7'h5C, 7'h3A);
        load_img();
        chk("model_L_allspace", exp_L, 63);
        go("allspace");
        chk("allspace_core0_lit", dut.mem.Core[0], 8'h20);

        // Randomized messages, taps, inits, with occasional corruption (including in the pad)
        for (int r = 0; r < 6; r++) begin
            pad = PM + $urandom_range(0, 4);
            for (int i = 0; i < 64; i++) pt[i] = (i < pad) ? 7'h20 : 7'($urandom_range(32, 126));
            encrypt(taps[$urandom_range(0, 8)], 7'($urandom_range(1, 127)));
            if (r >= 3) img[MB + $urandom_range(1, 63)] ^= (8'h01 << $urandom_range(0, 7));
            load_img();
            go($sformatf("rand%0d", r));
        end

        // Reset in the middle of the write phase, then relaunch
        set_msg("Mr. Watson, come here. I want to see you.", 10);
        encrypt(7'h60, 7'h01);
        load_img();
        Reset = 1'b0;
        Start = 1'b0;
        repeat (40) @(posedge Clk); #1;
        chk("midrun_busy_ack", Ack, 0);
        Reset = 1'b1;
        Start = 1'b1;
        @(posedge Clk); #1;
        chk("midrun_reset_ack", Ack, 0);
        go("relaunch");
        bad = 0;
        for (int i = 0; i < 64; i++) if (dut.mem.Core[i] !== ref29[i]) bad++;
        chk("relaunch_vs_watson", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
